// File: rtl/clk_gen_pkg.sv
// Shared constants and helpers for the clock-enable generator.
package clk_gen_pkg;

  // Default counter/divisor width.
  localparam int CNT_W_DEF = 32;

  // Default divisor: 50 MHz board clock slowed to 5 Hz for observation.
  localparam int unsigned DEFAULT_DIV_DEF = 32'd10000000;

  // Width used by the helper so it can serve any CNT_W up to 64.
  localparam int DIV_FN_W = 64;

  // Effective divisor: a programmed value of 0 behaves like 1.
  function automatic logic [DIV_FN_W-1:0] div_eff(input logic [DIV_FN_W-1:0] div);
    return (div == '0) ? DIV_FN_W'(1) : div;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/next divisor with pending flag,
// registered tick enable and square wave.
module clk_div_chan
  import clk_gen_pkg::*;
#(
  parameter int               CNT_W       = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(DEFAULT_DIV_DEF)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             force_tick,
  input  logic [CNT_W-1:0] div_in,
  input  logic             load,
  output logic             tick,
  output logic             sq,
  output logic             pend
);

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] div_reg, div_next;
  logic [CNT_W-1:0] nxt_div_reg, nxt_div_next;
  logic             pend_reg, pend_next;
  logic             tick_reg, tick_next;
  logic             sq_reg, sq_next;

  logic [CNT_W-1:0] cur_eff;
  logic [CNT_W-1:0] new_eff;
  logic             wrap;

  assign cur_eff = CNT_W'(div_eff(DIV_FN_W'(div_reg)));
  assign new_eff = CNT_W'(div_eff(DIV_FN_W'(div_next)));
  assign wrap    = (cnt_reg == cur_eff - CNT_W'(1));

  // Next-state: count, wrap and swap in a pending divisor only at a period boundary.
  always_comb begin
    cnt_next     = cnt_reg;
    div_next     = div_reg;
    nxt_div_next = nxt_div_reg;
    pend_next    = pend_reg;
    tick_next    = 1'b0;
    sq_next      = sq_reg;

    if (en) begin
      if (wrap) begin
        cnt_next  = '0;
        tick_next = 1'b1;
        if (pend_reg) begin
          div_next  = nxt_div_reg;
          pend_next = 1'b0;
        end
      end else begin
        cnt_next = cnt_reg + CNT_W'(1);
      end
      // First half of the (possibly new) period is high.
      sq_next = (cnt_next < (new_eff >> 1));
    end else begin
      tick_next = force_tick;
    end

    // A load always lands after the wrap decision, so a load on the wrap
    // cycle waits for the following wrap; the last load wins.
    if (load) begin
      nxt_div_next = div_in;
      pend_next    = 1'b1;
    end
  end

  // State register with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg     <= '0;
      div_reg     <= DEFAULT_DIV;
      nxt_div_reg <= DEFAULT_DIV;
      pend_reg    <= 1'b0;
      tick_reg    <= 1'b0;
      sq_reg      <= (DEFAULT_DIV >= CNT_W'(2));
    end else begin
      cnt_reg     <= cnt_next;
      div_reg     <= div_next;
      nxt_div_reg <= nxt_div_next;
      pend_reg    <= pend_next;
      tick_reg    <= tick_next;
      sq_reg      <= sq_next;
    end
  end

  assign tick = tick_reg;
  assign sq   = sq_reg;
  assign pend = pend_reg;

endmodule

// File: rtl/clk_enable_gen.sv
// Multi-channel clock-enable generator: step edge detector plus N_CH
// independent divider channels sharing one divisor input.
module clk_enable_gen
  import clk_gen_pkg::*;
#(
  parameter int               CNT_W       = CNT_W_DEF,
  parameter int               N_CH        = 2,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(DEFAULT_DIV_DEF)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] div_in,
  input  logic [N_CH-1:0]  div_load,
  input  logic             run,
  input  logic             step,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  sq,
  output logic [N_CH-1:0]  pend
);

  logic step_d_reg;
  logic step_ev;
  logic force_tick;

  // Remember last step level so a held button yields a single event.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_d_reg <= 1'b0;
    end else begin
      step_d_reg <= step;
    end
  end

  assign step_ev    = step & ~step_d_reg;
  // Steps only matter while frozen.
  assign force_tick = step_ev & ~run;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
      clk_div_chan #(
        .CNT_W      (CNT_W),
        .DEFAULT_DIV(DEFAULT_DIV)
      ) u_chan (
        .clk       (clk),
        .reset     (reset),
        .en        (run),
        .force_tick(force_tick),
        .div_in    (div_in),
        .load      (div_load[gi]),
        .tick      (tick[gi]),
        .sq        (sq[gi]),
        .pend      (pend[gi])
      );
    end
  endgenerate

endmodule

// File: doc/clk_enable_gen.md
# clk_enable_gen

Multi-channel programmable clock-enable generator; successor to the fixed single-output divider that slows the RISC-V core for board-level observation. It produces N_CH independent single-cycle tick enables and matching square waves from the one system clock, with runtime-loadable divisors applied glitch-free at period boundaries. A global run/step control supports single-stepping the core from a push-button. Sits at the top level between the board clock and the core, seven-segment refresh and other slow consumers, which use `tick` as a clock enable rather than as a derived clock.

## Interface
- `CNT_W`, 32, counter and divisor width
- `N_CH`, 2, number of independent channels (≥1)
- `DEFAULT_DIV`, 10000000, divisor loaded into every channel at reset (must be ≥1 and < 2^CNT_W)

- `clk`  in  1  system clock (50 MHz board clock)
- `reset`  in  1  asynchronous, active-low reset
- `div_in`  in  CNT_W  divisor value, shared by all channels
- `div_load`  in  N_CH  per-channel load strobe; bit i captures `div_in` for channel i
- `run`  in  1  1 = free-run, 0 = counters frozen (step mode)
- `step`  in  1  single-step request, already synchronous to `clk`; rising edge is the event
- `tick`  out  N_CH  one-cycle enable pulse per channel period
- `sq`  out  N_CH  square wave per channel, period = divisor
- `pend`  out  N_CH  divisor load pending for channel i

## Operation
- Per channel: `cnt`, active `div`, `nxt_div`, `pend` flag. div_eff = max(div, 1).
- Run (`run`=1): cnt increments each cycle; when cnt == div_eff−1, cnt ← 0 and tick ← 1 for one cycle; otherwise tick ← 0.
- `sq` ← 1 while next cnt < (div_eff >> 1), else 0; div_eff = 1 gives `sq` constant 0 and `tick` constant 1.
- Load: `div_load[i]` sets nxt_div ← `div_in`, pend ← 1. At the next wrap, div ← nxt_div, pend ← 0; the new period starts from cnt = 0. Loads never truncate a period in progress.
- Load on the same cycle as a wrap: the wrap uses the old div; the new value waits for the following wrap.
- Second load while pending: overwrites nxt_div; the last value wins.
- Stop (`run`=0): cnt, sq and div hold; tick = 0. Pending loads stay pending.
- Step (`run`=0): a `step` rising edge (registered `step_d`; event = step & ~step_d) asserts every tick bit for exactly one cycle. cnt, sq and pend are unchanged.
- Step with `run`=1 is ignored. A level held high produces one step only.
- Counter arithmetic is unsigned CNT_W; no overflow is possible, since cnt ≤ div_eff−1.

## Timing
- Reset values: cnt = 0, div = nxt_div = DEFAULT_DIV, pend = 0, tick = 0, sq = (DEFAULT_DIV ≥ 2), step_d = 0.
- After reset release, the first tick is high during the cycle after the div_eff-th rising edge. Ticks then repeat every div_eff cycles.
- All outputs are registered.
- `pend` rises the cycle after `div_load`.
- Step: tick is high in the cycle after the edge on which the step rising edge is sampled.
- `reset` asserted mid-period clears everything immediately (asynchronous). Pending loads are lost.
- `run` 1→0 on a wrap cycle: that wrap completes and its tick is emitted; counting freezes from the next edge.

## Structure
- Package `clk_gen_pkg`: default `CNT_W` and `DEFAULT_DIV` constants, plus function `div_eff(div)`.
- Sub-module `clk_div_chan`: one channel (counter, div/nxt_div/pend, tick, sq) with inputs `clk`, `reset`, `en`, `force_tick`, `div_in`, `load`. It is instantiated N_CH times in a generate loop.
- Top level holds only the step edge detector and the fan-out.

## Test plan
- Reset, DEFAULT_DIV = 4, `run` = 1 → tick high at cycles 4, 8, 12; sq pattern 1,1,0,0 repeating; pend = 0.
- Load ch0 `div_in` = 6 mid-period → pend[0] = 1; the current 4-cycle period completes, then the tick spacing becomes 6 and pend[0] clears at the wrap; ch1 is unaffected.
- Load on the exact wrap cycle, then a second load of 2 before the next wrap → the period after next uses 2; the intermediate value is never applied.
- `div_in` = 0 and 1 → tick high every cycle, sq = 0.
- `run` = 0, `step` held high 10 cycles → exactly one tick on all channels, cnt unchanged; `step` pulse with `run` = 1 → no extra tick.
- Assert `reset` mid-period with a load pending → all outputs return to reset values asynchronously; DEFAULT_DIV is restored.
